bus_sequencer: RTL and testbench

Command-driven bus master that sits directly upstream of the 4x16 register file and drives its address, write-enable, read-enable and write-data lines. It accepts one transfer command at a time over a valid/ready handshake. Each command expands into a fixed sequence of bus cycles: read source, optionally read destination, then write back or return a result. It is the first control stage between the instruction source and the register file on the shared 16-bit bus.

---
 rtl/bus_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_bus_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// Command-driven bus master for the 4x16 register file: expands MOV/LOAD/ADD/READ
// commands into read-source / read-destination / write-back / response bus cycles.
module bus_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 4
) (
    input  logic                  bus_sequencer_clock,
    input  logic                  bus_sequencer_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_src,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [ADDR_WIDTH-1:0] register_addr,
    output logic                  bus_register_input_en,
    output logic                  bus_register_out_en,
    output logic [DATA_WIDTH-1:0] bus_register_input,
    input  logic [DATA_WIDTH-1:0] bus_register_output,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] result_data,
    output logic                  carry,
    output logic                  cmd_err,
    output logic                  busy
);

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] REG_LIMIT = ADDR_WIDTH'(NUM_REGS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_SRC = 3'd1,
        RD_DST = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4,
        ERR    = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              opCode_q;
    logic [ADDR_WIDTH-1:0]   srcAddr_q;
    logic [ADDR_WIDTH-1:0]   dstAddr_q;
    logic [DATA_WIDTH-1:0]   immData_q;
    logic [DATA_WIDTH-1:0]   operandA_q;
    logic [DATA_WIDTH-1:0]   operandB_q;
    logic [DATA_WIDTH-1:0]   resultData_q;
    logic                    carry_q;
    logic [ADDR_WIDTH-1:0]   busAddr_q, busAddr_d;

    logic                    cmdAccept;
    logic                    cmdLegal;
    logic [DATA_WIDTH:0]     sumFull;
    logic                    outEn;
    logic                    inEn;
    logic [DATA_WIDTH-1:0]   writeData;

    function automatic logic addrOk(input logic [ADDR_WIDTH-1:0] addr);
        return addr < REG_LIMIT;
    endfunction

    assign cmdAccept = (state_q == IDLE) && cmd_valid;
    assign sumFull   = {1'b0, operandA_q} + {1'b0, operandB_q};

    // Only the addresses an op actually touches are range-checked.
    always_comb begin
        cmdLegal = 1'b0;
        unique case (cmd_op)
            OP_MOV,
            OP_ADD:  cmdLegal = addrOk(cmd_src) && addrOk(cmd_dst);
            OP_LOAD: cmdLegal = addrOk(cmd_dst);
            OP_READ: cmdLegal = addrOk(cmd_src);
            default: cmdLegal = 1'b0;
        endcase
    end

    always_ff @(posedge bus_sequencer_clock) begin
        if (bus_sequencer_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (!cmdLegal) begin
                        state_d = ERR;
                    end else if (cmd_op == OP_LOAD) begin
                        state_d = WR;
                    end else begin
                        state_d = RD_SRC;
                    end
                end
            end
            RD_SRC: begin
                if (opCode_q == OP_ADD) begin
                    state_d = RD_DST;
                end else if (opCode_q == OP_READ) begin
                    state_d = RESP;
                end else begin
                    state_d = WR;
                end
            end
            RD_DST:  state_d = WR;
            WR:      state_d = IDLE;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        writeData = '0;
        unique case (opCode_q)
            OP_MOV:  writeData = operandA_q;
            OP_LOAD: writeData = immData_q;
            OP_ADD:  writeData = sumFull[DATA_WIDTH-1:0];
            default: writeData = '0;
        endcase
    end

    // Bus drive is a pure function of state; the address register keeps the
    // last driven address stable whenever no bus cycle is in progress.
    always_comb begin
        busAddr_d = busAddr_q;
        outEn     = 1'b0;
        inEn      = 1'b0;
        unique case (state_q)
            RD_SRC: begin
                busAddr_d = srcAddr_q;
                outEn     = 1'b1;
            end
            RD_DST: begin
                busAddr_d = dstAddr_q;
                outEn     = 1'b1;
            end
            WR: begin
                busAddr_d = dstAddr_q;
                inEn      = 1'b1;
            end
            default: begin
                busAddr_d = busAddr_q;
            end
        endcase
    end

    assign register_addr         = busAddr_d;
    assign bus_register_out_en   = outEn;
    assign bus_register_input_en = inEn;
    assign bus_register_input    = inEn ? writeData : '0;
    assign cmd_ready             = (state_q == IDLE);
    assign busy                  = (state_q != IDLE);
    assign result_valid          = (state_q == RESP);
    assign cmd_err               = (state_q == ERR);
    assign result_data           = resultData_q;
    assign carry                 = carry_q;

    // READ results are taken straight off the bus so they are already valid
    // during the RESP pulse.
    always_ff @(posedge bus_sequencer_clock) begin
        if (bus_sequencer_reset) begin
            opCode_q     <= OP_MOV;
            srcAddr_q    <= '0;
            dstAddr_q    <= '0;
            immData_q    <= '0;
            operandA_q   <= '0;
            operandB_q   <= '0;
            resultData_q <= '0;
            carry_q      <= 1'b0;
            busAddr_q    <= '0;
        end else begin
            if (cmdAccept) begin
                opCode_q  <= cmd_op;
                srcAddr_q <= cmd_src;
                dstAddr_q <= cmd_dst;
                immData_q <= cmd_imm;
            end
            if (state_q == RD_SRC) begin
                operandA_q <= bus_register_output;
            end
            if (state_q == RD_SRC && opCode_q == OP_READ) begin
                resultData_q <= bus_register_output;
            end
            if (state_q == RD_DST) begin
                operandB_q <= bus_register_output;
            end
            if (state_q == WR && opCode_q == OP_ADD) begin
                carry_q <= sumFull[DATA_WIDTH];
            end
            busAddr_q <= busAddr_d;
        end
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: a register-file model answers bus reads,
// directed commands queue the expected bus events, a negedge monitor checks them.
module tb_bus_sequencer;

    localparam int DW = 16;
    localparam int AW = 6;

    localparam logic [7:0] K_RD  = 8'd1;
    localparam logic [7:0] K_WR  = 8'd2;
    localparam logic [7:0] K_RES = 8'd3;
    localparam logic [7:0] K_ERR = 8'd4;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    typedef struct packed {
        logic [7:0]  kind;
        logic [7:0]  addr;
        logic [15:0] data;
    } evt_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmdValid = 1'b0;
    logic          cmdReady;
    logic [1:0]    cmdOp = 2'b00;
    logic [AW-1:0] cmdSrc = '0;
    logic [AW-1:0] cmdDst = '0;
    logic [DW-1:0] cmdImm = '0;
    logic [AW-1:0] regAddr;
    logic          inEn;
    logic          outEn;
    logic [DW-1:0] busIn;
    logic [DW-1:0] busOut;
    logic          resultValid;
    logic [DW-1:0] resultData;
    logic          carryOut;
    logic          cmdErr;
    logic          busyOut;

    logic [DW-1:0] regFile [4];
    evt_t          expQ[$];
    int            total = 0;
    int            bad = 0;
    bit            monitorOn = 1'b0;

    always #5 clock = ~clock;

    bus_sequencer dut (
        .bus_sequencer_clock   (clock),
        .bus_sequencer_reset   (reset),
        .cmd_valid             (cmdValid),
        .cmd_ready             (cmdReady),
        .cmd_op                (cmdOp),
        .cmd_src               (cmdSrc),
        .cmd_dst               (cmdDst),
        .cmd_imm               (cmdImm),
        .register_addr         (regAddr),
        .bus_register_input_en (inEn),
        .bus_register_out_en   (outEn),
        .bus_register_input    (busIn),
        .bus_register_output   (busOut),
        .result_valid          (resultValid),
        .result_data           (resultData),
        .carry                 (carryOut),
        .cmd_err               (cmdErr),
        .busy                  (busyOut)
    );

    // Register file model sharing the sequencer's reset; contents 0,1,2,3 after reset.
    assign busOut = outEn ? regFile[regAddr[1:0]] : 16'h0000;

    always @(posedge clock) begin
        if (reset) begin
            regFile[0] <= 16'd0;
            regFile[1] <= 16'd1;
            regFile[2] <= 16'd2;
            regFile[3] <= 16'd3;
        end else if (inEn) begin
            regFile[regAddr[1:0]] <= busIn;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every strobe, result pulse or error pulse must match the queue head.
    always @(negedge clock) begin
        evt_t seen;
        bit   have;
        have = 1'b0;
        seen = '0;
        if (monitorOn) begin
            if (inEn === 1'b1 && outEn === 1'b1) begin
                checkOutput("strobeOverlap", {30'd0, inEn, outEn}, 32'd0);
            end
            if (outEn === 1'b1) begin
                seen = {K_RD, {(8-AW){1'b0}}, regAddr, busIn};
                have = 1'b1;
            end else if (inEn === 1'b1) begin
                seen = {K_WR, {(8-AW){1'b0}}, regAddr, busIn};
                have = 1'b1;
            end else if (resultValid === 1'b1) begin
                seen = {K_RES, 8'h00, resultData};
                have = 1'b1;
            end else if (cmdErr === 1'b1) begin
                seen = {K_ERR, 8'h00, 16'h0000};
                have = 1'b1;
            end
            if (have) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedEvent: got %h expected none", seen);
                end else begin
                    checkOutput("scoreboard", seen, expQ.pop_front());
                end
            end
        end
    end

    task automatic expRd(input logic [7:0] addr);
        expQ.push_back({K_RD, addr, 16'h0000});
    endtask

    task automatic expWr(input logic [7:0] addr, input logic [15:0] data);
        expQ.push_back({K_WR, addr, data});
    endtask

    task automatic expRes(input logic [15:0] data);
        expQ.push_back({K_RES, 8'h00, data});
    endtask

    task automatic expErr();
        expQ.push_back({K_ERR, 8'h00, 16'h0000});
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".addr"},        {26'd0, regAddr},    32'd0);
        checkOutput({tag, ".inEn"},        {31'd0, inEn},       32'd0);
        checkOutput({tag, ".outEn"},       {31'd0, outEn},      32'd0);
        checkOutput({tag, ".busIn"},       {16'd0, busIn},      32'd0);
        checkOutput({tag, ".resultValid"}, {31'd0, resultValid},32'd0);
        checkOutput({tag, ".resultData"},  {16'd0, resultData}, 32'd0);
        checkOutput({tag, ".carry"},       {31'd0, carryOut},   32'd0);
        checkOutput({tag, ".cmdErr"},      {31'd0, cmdErr},     32'd0);
        checkOutput({tag, ".busy"},        {31'd0, busyOut},    32'd0);
        checkOutput({tag, ".cmdReady"},    {31'd0, cmdReady},   32'd1);
    endtask

    task automatic doReset(input string tag);
        cmdValid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        checkResetState(tag);
        reset = 1'b0;
    endtask

    // Issue one command and measure how many cycles cmd_ready stays low.
    task automatic applyStimulus(input string name, input logic [1:0] op, input logic [AW-1:0] src,
                                 input logic [AW-1:0] dst, input logic [DW-1:0] imm, input int expLatency);
        int lowCycles;
        for (int i = 0; i < 20 && cmdReady !== 1'b1; i++) begin
            @(posedge clock);
            #1;
        end
        if (cmdReady !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL %s.readyTimeout: got %b expected 1", name, cmdReady);
        end
        cmdOp    = op;
        cmdSrc   = src;
        cmdDst   = dst;
        cmdImm   = imm;
        cmdValid = 1'b1;
        @(posedge clock);
        #1;
        cmdValid = 1'b0;
        cmdOp    = 2'b11;
        cmdSrc   = 6'h3F;
        cmdDst   = 6'h3F;
        cmdImm   = 16'hA5A5;
        lowCycles = 0;
        while (cmdReady !== 1'b1 && lowCycles < 10) begin
            @(posedge clock);
            #1;
            lowCycles++;
        end
        checkOutput({name, ".latency"}, lowCycles, expLatency);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset("reset0");
        monitorOn = 1'b1;

        expRd(8'd2); expRes(16'h0002);
        applyStimulus("read2", OP_READ, 6'd2, 6'd0, 16'h0000, 2);
        checkOutput("read2.resultHeld", {16'd0, resultData}, 32'h0002);

        expWr(8'd1, 16'hBEEF);
        applyStimulus("load1", OP_LOAD, 6'd0, 6'd1, 16'hBEEF, 1);
        expRd(8'd1); expRes(16'hBEEF);
        applyStimulus("read1", OP_READ, 6'd1, 6'd0, 16'h0000, 2);

        expWr(8'd0, 16'hFFFF);
        applyStimulus("load0", OP_LOAD, 6'd0, 6'd0, 16'hFFFF, 1);
        expWr(8'd3, 16'h0002);
        applyStimulus("load3", OP_LOAD, 6'd0, 6'd3, 16'h0002, 1);
        expRd(8'd0); expRd(8'd3); expWr(8'd3, 16'h0001);
        applyStimulus("addCarry", OP_ADD, 6'd0, 6'd3, 16'h0000, 3);
        checkOutput("addCarry.carry", {31'd0, carryOut}, 32'd1);
        checkOutput("addCarry.addrHeld", {26'd0, regAddr}, 32'd3);

        doReset("reset1");
        expRd(8'd3); expWr(8'd0, 16'h0003);
        applyStimulus("mov30", OP_MOV, 6'd3, 6'd0, 16'h0000, 2);
        expRd(8'd0); expRes(16'h0003);
        applyStimulus("read0", OP_READ, 6'd0, 6'd0, 16'h0000, 2);

        expErr();
        applyStimulus("movIllegal", OP_MOV, 6'd5, 6'd1, 16'h0000, 1);
        expErr();
        applyStimulus("loadIllegal", OP_LOAD, 6'd0, 6'd4, 16'h1234, 1);
        expRd(8'd1); expRes(16'h0001);
        applyStimulus("read1Unchanged", OP_READ, 6'd1, 6'd0, 16'h0000, 2);

        expRd(8'd2); expRd(8'd1); expWr(8'd1, 16'h0003);
        applyStimulus("addNoCarry", OP_ADD, 6'd2, 6'd1, 16'h0000, 3);
        checkOutput("addNoCarry.carry", {31'd0, carryOut}, 32'd0);
        expRd(8'd3); expRd(8'd3); expWr(8'd3, 16'h0006);
        applyStimulus("addDouble", OP_ADD, 6'd3, 6'd3, 16'h0000, 3);
        expRd(8'd1); expRes(16'h0003);
        applyStimulus("read1Sum", OP_READ, 6'd1, 6'd0, 16'h0000, 2);
        expRd(8'd3); expRes(16'h0006);
        applyStimulus("read3Sum", OP_READ, 6'd3, 6'd0, 16'h0000, 2);

        // ADD aborted by reset during its RD_DST cycle: two reads, no write.
        expRd(8'd1); expRd(8'd2);
        cmdOp = OP_ADD; cmdSrc = 6'd1; cmdDst = 6'd2; cmdImm = 16'h0000;
        cmdValid = 1'b1;
        @(posedge clock);
        #1;
        cmdValid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkResetState("abort");
        reset = 1'b0;
        expRd(8'd2); expRes(16'h0002);
        applyStimulus("read2AfterAbort", OP_READ, 6'd2, 6'd0, 16'h0000, 2);

        repeat (3) @(posedge clock);
        #1;
        checkOutput("queueEmpty", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
